// File: rtl/shaper_queue.sv
// Ingress FIFO ahead of a token-bucket limiter: one request per head item, release on grant.
// Optional build macro SHAPER_QUEUE_DROP_ON_FULL_EN: drop pushes while full and count them.
module shaper_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     req_o,
  input  logic                     grant_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
  ,
  output logic [15:0]              drop_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, REQ, CHECK, OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              push;
  logic              pop;
  logic [AW:0]       level_next;

  assign full = (level_o == FULL_LVL);

`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
  assign in_ready = 1'b1;
  assign push     = in_valid && !full;
`else
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
`endif

  // Only a grant seen in CHECK answers our own request; grants elsewhere are stray.
  assign pop        = (state == CHECK) && grant_i && (level_o != '0);
  assign level_next = level_o + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_o   <= '0;
      req_o     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      level_o <= level_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (level_o != '0) begin
            state <= REQ;
            req_o <= 1'b1;
          end
        end
        REQ: begin
          state <= CHECK;
          req_o <= 1'b0;
        end
        CHECK: begin
          if (pop) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= REQ;
            req_o <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (level_next != '0) begin
              state <= REQ;
              req_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
    end else if (in_valid && full && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shaper_queue.sv
// Scoreboard bench for shaper_queue: bench-side token bucket, FIFO-order model and occupancy model.
// Build with SHAPER_QUEUE_DROP_ON_FULL_EN defined to exercise the drop-on-full variant.
module tb_shaper_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              req_o;
  logic              grant_i = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level_o;
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
  logic [15:0]       drop_cnt_o;
`endif

  shaper_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_o(req_o), .grant_i(grant_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level_o(level_o)
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side token bucket: answers a request one cycle later; strays only when no request is pending.
  int   grant_pct = 100;
  int   stray_pct = 0;
  int   deny_cnt  = 0;
  logic req_d     = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      req_d = rst_n && req_o;
      @(posedge clk);
      #1;
      if (req_d && deny_cnt > 0) begin
        deny_cnt--;
        grant_i = 1'b0;
      end else if (req_d) begin
        grant_i = ($urandom_range(99) < grant_pct);
      end else begin
        grant_i = ($urandom_range(99) < stray_pct);
      end
    end
  end

  // Scoreboard and monitor
  logic [DATA_W-1:0] exp_q[$];
  int                pushed = 0, popped = 0, drops = 0, req_total = 0;
  logic              prev_valid = 0, prev_hold = 0, prev_hs = 0, prev_req = 0;
  logic [DATA_W-1:0] prev_data = '0, last_data = '0;

  initial begin
    int lvl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pushed = 0; popped = 0; drops = 0;
        prev_valid = 0; prev_hold = 0; prev_hs = 0; prev_req = 0;
        last_data = '0;
      end else begin
        if (out_valid && !prev_valid) begin
          popped++;
          if (exp_q.size() == 0) chk("spurious_out", 1, 0);
          else begin
            chk("out_data", out_data, exp_q[0]);
            last_data = exp_q[0];
          end
        end
        lvl = pushed - popped;
        chk("level", level_o, lvl);
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
        chk("in_ready", in_ready, 1);
        chk("drop_cnt", drop_cnt_o, drops);
`else
        chk("in_ready", in_ready, (lvl < DEPTH) ? 1 : 0);
`endif
        chk("req_gap", (prev_req && req_o) ? 1 : 0, 0);
        chk("req_in_out", (req_o && out_valid) ? 1 : 0, 0);
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
        end
        if (prev_hs) chk("valid_drop", out_valid, 0);
        if (!out_valid) chk("retain", out_data, last_data);
        if (req_o) req_total++;
        if (out_valid && out_ready && exp_q.size() > 0) begin
          chk("out_item", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
          if (lvl >= DEPTH) begin
            if (drops < 65535) drops++;
          end else begin
            exp_q.push_back(in_data);
            pushed++;
          end
`else
          exp_q.push_back(in_data);
          pushed++;
`endif
        end
        prev_valid = out_valid;
        prev_hold  = out_valid && !out_ready;
        prev_hs    = out_valid && out_ready;
        prev_req   = req_o;
        prev_data  = out_data;
      end
    end
  end

  task automatic push(input logic [DATA_W-1:0] d);
    logic acc;
    int   budget;
    acc = 0;
    budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int budget;
    logic done;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    grant_pct = 100;
    stray_pct = 0;
    budget = 0;
    done = 0;
    while (!done && budget < 300) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
      budget++;
    end
    chk("drain_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int r0;
    logic found;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_level", level_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", req_o, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;

    // Single-item latency with an always-granting bucket
    push(8'hA5);
    wait_valid(cyc);
    chk("latency", cyc, 4);
    chk("lat_data", out_data, 8'hA5);
    drain();
    chk("lat_level", level_o, 0);

    // Three refused requests, granted on the fourth
    deny_cnt = 3;
    r0 = req_total;
    push(8'h3C);
    wait_valid(cyc);
    @(posedge clk);
    #1;
    chk("retry_reqs", req_total - r0, 4);
    drain();

    // Fill with no grants
    grant_pct = 0;
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
`ifdef SHAPER_QUEUE_DROP_ON_FULL_EN
    push(8'd5); push(8'd6);
    repeat (3) @(negedge clk);
    chk("full_level", level_o, 4);
    chk("full_drops", drop_cnt_o, 2);
    @(posedge clk);
    #1;
    grant_pct = 100;
`else
    fork
      push(8'd5);
      begin
        repeat (4) @(negedge clk);
        chk("full_level", level_o, 4);
        chk("full_in_ready", in_ready, 0);
        grant_pct = 100;
      end
    join
`endif
    drain();

    // Output held under backpressure, stray grants ignored
    out_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    wait_valid(cyc);
    stray_pct = 100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid_dir", out_valid, 1);
      chk("hold_data_dir", out_data, 8'h11);
      chk("hold_req", req_o, 0);
      chk("hold_level", level_o, 1);
    end
    @(posedge clk);
    #1;
    drain();

    // Reset while in CHECK with two items queued
    grant_pct = 0;
    push(8'h77);
    push(8'h88);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = req_o && (level_o == 3'd2);
    end
    chk("rst_check_reached", found, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_req", req_o, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    grant_pct = 100;
    @(posedge clk);
    #1;

    // Randomized traffic
    grant_pct = 70;
    stray_pct = 30;
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom());
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
